ifu_fetch_ctrl: RTL and testbench

- Fetch sequencer that owns the Program Counter's update path. Drives the PC block's set_pc/new_pc every cycle so the PC holds during stalls, advances by 4 on instruction hand-off, or jumps on a redirect.
- Issues one outstanding instruction-memory read at a time, buffers the returned word, and presents it to decode with a valid/ready handshake.
- Sits between the PC block, the instruction memory port and the decode/execute stages.

---
 rtl/ifu_fetch_ctrl.sv | 138 +++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch sequencer: drives the PC update path, issues one imem read at a time and
// hands the buffered word to decode. Define IFU_FETCH_PERF_EN to add fetch/stall counters.
//   state | meaning
//   IDLE  | out of reset, latch first fetch address
//   REQ   | imem request presented, waiting for ready
//   WAIT  | request accepted, waiting for response
//   OUT   | instruction buffered, offered to decode
module ifu_fetch_ctrl #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] START_ADDR = 32'h8000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_in,
  output logic             set_pc,
  output logic [WIDTH-1:0] new_pc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] inst_pc,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc
`ifdef IFU_FETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetch_cnt,
  output logic [31:0]      perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_e;

  state_e           state_q, state_d;
  logic             discard_q, discard_d;
  logic [WIDTH-1:0] req_addr_q, req_addr_d;
  logic [WIDTH-1:0] inst_q, inst_d;
  logic [WIDTH-1:0] inst_pc_q, inst_pc_d;
  logic [WIDTH-1:0] nxt_pc;
  logic             inst_hs;

  assign imem_req_valid = (state_q == S_REQ);
  assign inst_valid     = (state_q == S_OUT);
  assign imem_req_addr  = req_addr_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign inst_hs        = inst_valid && inst_ready;

  // PC block follows set_pc/new_pc; nxt_pc mirrors the value it will hold after this edge
  always_comb begin
    set_pc = 1'b1;
    new_pc = pc_in;
    if (redirect_valid) begin
      new_pc = redirect_pc;
    end else if (inst_hs) begin
      set_pc = 1'b0;
    end
    nxt_pc = set_pc ? new_pc : pc_in + WIDTH'(4);
  end

  always_comb begin
    state_d    = state_q;
    discard_d  = discard_q;
    req_addr_d = req_addr_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    case (state_q)
      S_IDLE: begin
        state_d    = S_REQ;
        req_addr_d = nxt_pc;
      end
      S_REQ: begin
        // request cannot be withdrawn, so a redirect here only marks its response stale
        if (redirect_valid) discard_d = 1'b1;
        if (imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (discard_q || redirect_valid) begin
            discard_d  = 1'b0;
            state_d    = S_REQ;
            req_addr_d = nxt_pc;
          end else begin
            inst_d    = imem_rsp_data;
            inst_pc_d = req_addr_q;
            state_d   = S_OUT;
          end
        end else if (redirect_valid) begin
          discard_d = 1'b1;
        end
      end
      S_OUT: begin
        if (redirect_valid || inst_ready) begin
          state_d    = S_REQ;
          req_addr_d = nxt_pc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      discard_q  <= 1'b0;
      req_addr_q <= START_ADDR;
      inst_q     <= '0;
      inst_pc_q  <= START_ADDR;
    end else begin
      state_q    <= state_d;
      discard_q  <= discard_d;
      req_addr_q <= req_addr_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
    end
  end

`ifdef IFU_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (inst_hs) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (state_q == S_REQ || state_q == S_WAIT) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Randomized bench for ifu_fetch_ctrl: PC block and memory modelled here, checked against an
// architectural PC-stream model (expected fetch PC, one outstanding read, stable handshakes).
module tb_ifu_fetch_ctrl;
  localparam logic [31:0] START = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        set_pc;
  logic [31:0] new_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef IFU_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  ifu_fetch_ctrl #(.WIDTH(32), .START_ADDR(START)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .set_pc(set_pc), .new_pc(new_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
`ifdef IFU_FETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  // PC block: resets with the same reset, loads new_pc or increments by 4
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_in <= START;
    else      pc_in <= set_pc ? new_pc : pc_in + 32'd4;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a ^ 32'h8000_0013;
  endfunction

  logic [31:0] exp_pc;
  logic        pending;
  logic [31:0] pend_addr;
  int          wait_cnt;
  int          lat;
  logic        prev_rv, prev_rr, prev_iv, prev_ir, prev_redir;
  logic [31:0] prev_addr, prev_inst, prev_inst_pc;
  logic [31:0] last_launch;
  int          idle_cycles;
  int          hs_cnt;
  int          stall_cnt;

  task automatic model_reset();
    exp_pc      = START;
    pending     = 1'b0;
    wait_cnt    = 0;
    prev_rv     = 1'b0;
    prev_rr     = 1'b0;
    prev_iv     = 1'b0;
    prev_ir     = 1'b0;
    prev_redir  = 1'b0;
    prev_addr   = '0;
    prev_inst   = '0;
    prev_inst_pc = '0;
    idle_cycles = 0;
    hs_cnt      = 0;
    stall_cnt   = 0;
  endtask

  task automatic step(input logic redir, input logic [31:0] tgt, input logic iready,
                      input logic rready);
    logic busy;
    logic hs;
    @(negedge clk);
    redirect_valid = redir;
    redirect_pc    = tgt;
    inst_ready     = iready;
    imem_req_ready = rready;
    imem_rsp_valid = 1'b0;
    busy = pending;
    if (pending) begin
      if (wait_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memfn(pend_addr);
        pending        = 1'b0;
      end else begin
        wait_cnt--;
      end
    end
    #1;
    hs = inst_valid && iready;
    chk_val("pc_in", pc_in, exp_pc);
    if (redir) begin
      chk_val("set_pc_redir", {31'b0, set_pc}, 32'd1);
      chk_val("new_pc_redir", new_pc, tgt);
    end else if (hs) begin
      chk_val("set_pc_adv", {31'b0, set_pc}, 32'd0);
      chk_val("new_pc_adv", new_pc, exp_pc);
    end else begin
      chk_val("set_pc_hold", {31'b0, set_pc}, 32'd1);
      chk_val("new_pc_hold", new_pc, exp_pc);
    end
    if (busy) chk_val("one_outstanding", {31'b0, imem_req_valid}, 32'd0);
    if (imem_req_valid && !prev_rv) begin
      chk_val("req_launch_addr", imem_req_addr, exp_pc);
      last_launch = imem_req_addr;
    end
    if (prev_rv && !prev_rr) begin
      chk_val("req_valid_held", {31'b0, imem_req_valid}, 32'd1);
      chk_val("req_addr_stable", imem_req_addr, prev_addr);
    end
    if (prev_iv && !prev_ir && !prev_redir) begin
      chk_val("inst_valid_held", {31'b0, inst_valid}, 32'd1);
      chk_val("inst_stable", inst, prev_inst);
      chk_val("inst_pc_stable", inst_pc, prev_inst_pc);
    end
    if (hs) begin
      chk_val("inst_pc", inst_pc, exp_pc);
      chk_val("inst_data", inst, memfn(exp_pc));
      hs_cnt++;
      idle_cycles = 0;
    end else begin
      idle_cycles++;
    end
    if (imem_req_valid || busy) stall_cnt++;
    if (redir)   exp_pc = tgt;
    else if (hs) exp_pc = exp_pc + 32'd4;
    if (imem_req_valid && rready) begin
      pending   = 1'b1;
      pend_addr = imem_req_addr;
      wait_cnt  = lat;
    end
    prev_rv      = imem_req_valid;
    prev_rr      = rready;
    prev_addr    = imem_req_addr;
    prev_iv      = inst_valid;
    prev_ir      = iready;
    prev_redir   = redir;
    prev_inst    = inst;
    prev_inst_pc = inst_pc;
  endtask

  task automatic run_until_out();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      step(1'b0, 32'd0, 1'b0, 1'b1);
      seen = inst_valid;
    end
    if (!seen) chk_val("timeout_out", {31'b0, inst_valid}, 32'd1);
  endtask

  task automatic chk_reset_vals();
    chk_val("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk_val("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk_val("rst_req_addr", imem_req_addr, START);
    chk_val("rst_inst", inst, 32'd0);
    chk_val("rst_inst_pc", inst_pc, START);
`ifdef IFU_FETCH_PERF_EN
    chk_val("rst_perf_fetch", perf_fetch_cnt, 32'd0);
    chk_val("rst_perf_stall", perf_stall_cnt, 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    lat            = 0;
    last_launch    = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst = 1'b1;

    // first fetch after reset
    run_until_out();
    chk_val("first_req_addr", last_launch, START);
    chk_val("first_inst", inst, 32'h0000_0013);
    chk_val("first_inst_pc", inst_pc, START);
    step(1'b0, 32'd0, 1'b1, 1'b1);

    // decode stalls on second instruction
    run_until_out();
    chk_val("second_req_addr", last_launch, START + 32'd4);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 32'd0, 1'b0, 1'b1);
      chk_val("stall_set_pc", {31'b0, set_pc}, 32'd1);
      chk_val("stall_pc_in", pc_in, START + 32'd4);
      chk_val("stall_inst", inst, memfn(START + 32'd4));
    end
    step(1'b0, 32'd0, 1'b1, 1'b1);

    // redirect while waiting for the response
    lat = 2;
    step(1'b0, 32'd0, 1'b0, 1'b1);
    step(1'b1, 32'h8000_0100, 1'b0, 1'b1);
    lat = 0;
    run_until_out();
    chk_val("wait_redir_req", last_launch, 32'h8000_0100);
    chk_val("wait_redir_inst_pc", inst_pc, 32'h8000_0100);
    step(1'b0, 32'd0, 1'b1, 1'b1);

    // memory not ready, redirect during REQ
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'd0, 1'b0, 1'b0);
      chk_val("req_held_addr", imem_req_addr, 32'h8000_0104);
    end
    step(1'b1, 32'h8000_0200, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    chk_val("req_redir_old_addr", imem_req_addr, 32'h8000_0104);
    run_until_out();
    chk_val("req_redir_next", last_launch, 32'h8000_0200);
    chk_val("req_redir_inst_pc", inst_pc, 32'h8000_0200);

    // redirect and handshake together in OUT
    step(1'b1, 32'h8000_0300, 1'b1, 1'b1);
    chk_val("out_redir_set_pc", {31'b0, set_pc}, 32'd1);
    chk_val("out_redir_new_pc", new_pc, 32'h8000_0300);
    run_until_out();
    chk_val("out_redir_next", last_launch, 32'h8000_0300);

    // PC wrap at top of address space
    step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    run_until_out();
    chk_val("wrap_top_pc", inst_pc, 32'hFFFF_FFFC);
    step(1'b0, 32'd0, 1'b1, 1'b1);
    run_until_out();
    chk_val("wrap_zero_pc", inst_pc, 32'h0000_0000);

    // asynchronous reset in WAIT
    step(1'b0, 32'd0, 1'b1, 1'b1);
    lat = 3;
    step(1'b0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_vals();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    lat = 0;
    run_until_out();
    chk_val("restart_inst_pc", inst_pc, START);
    chk_val("restart_req", last_launch, START);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic        rd;
      logic [31:0] tg;
      rd  = ($urandom_range(0, 9) == 0);
      tg  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4)
                                        : ($urandom & 32'hFFFF_FFFC);
      lat = $urandom_range(0, 3);
      step(rd, tg, ($urandom_range(0, 9) < 6), ($urandom_range(0, 3) != 0));
      if (idle_cycles > 200) begin
        chk_val("liveness", idle_cycles, 0);
        idle_cycles = 0;
      end
    end

`ifdef IFU_FETCH_PERF_EN
    @(negedge clk);
    #1;
    chk_val("perf_fetch", perf_fetch_cnt, hs_cnt);
    chk_val("perf_stall", perf_stall_cnt, stall_cnt);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
